updn_counter_param: RTL and testbench

Parametrised up/down counter: the next-generation replacement for the fixed 5-bit up/down counter. Adds configurable width, runtime lower/upper limits, a saturate-or-wrap mode, registered overflow/underflow event pulses and an optional programmable step. With limits tied to 0 and all-ones, wrap mode off and step 1, it behaves as the legacy 5-bit counter, except that `Down` wins whenever asserted. It sits wherever the design needs a bounded event counter, timer or pointer.

---
 rtl/updn_counter_param.sv | 96 +++++++++
 tb/tb_updn_counter_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/updn_counter_param.sv
// Parametrised bounded up/down counter with saturate/wrap mode and registered ovf/udf pulses.
// Define UPDN_STEP_EN to add a per-cycle programmable `step` port; otherwise the step is fixed at 1.
module updn_counter_param #(
    parameter int unsigned      WIDTH   = 5,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] IN,
    input  logic             load,
    input  logic             Down,
    input  logic             Up,
    input  logic             wrap_en,
    input  logic [WIDTH-1:0] lim_lo,
    input  logic [WIDTH-1:0] lim_hi,
`ifdef UPDN_STEP_EN
    input  logic [WIDTH-1:0] step,
`endif
    output logic [WIDTH-1:0] Counter,
    output logic             High,
    output logic             Low,
    output logic             ovf,
    output logic             udf,
    output logic             cfg_err
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic             r_udf;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH:0]   w_up_sum;
    logic [WIDTH:0]   w_dn_floor;
    logic             w_up_bnd;
    logic             w_dn_bnd;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;
    logic             w_udf_nxt;

`ifdef UPDN_STEP_EN
    assign w_step = step;
`else
    assign w_step = WIDTH'(1);
`endif

    // One extra bit so limit comparisons never see a truncated sum.
    assign w_up_sum   = {1'b0, r_cnt}  + {1'b0, w_step};
    assign w_dn_floor = {1'b0, lim_lo} + {1'b0, w_step};
    assign w_up_bnd   = (r_cnt >= lim_hi) || (w_up_sum > {1'b0, lim_hi});
    assign w_dn_bnd   = (r_cnt <= lim_lo) || ({1'b0, r_cnt} < w_dn_floor);

    assign cfg_err = (lim_lo > lim_hi);
    assign High    = (r_cnt >= lim_hi);
    assign Low     = (r_cnt <= lim_lo);
    assign Counter = r_cnt;
    assign ovf     = r_ovf;
    assign udf     = r_udf;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = 1'b0;
        w_udf_nxt = 1'b0;
        if (load) begin
            w_cnt_nxt = IN;
        end else if (cfg_err) begin
            w_cnt_nxt = r_cnt;
        end else if (Down) begin
            if (w_dn_bnd) begin
                w_cnt_nxt = wrap_en ? lim_hi : lim_lo;
                w_udf_nxt = wrap_en;
            end else begin
                w_cnt_nxt = r_cnt - w_step;
            end
        end else if (Up) begin
            if (w_up_bnd) begin
                w_cnt_nxt = wrap_en ? lim_lo : lim_hi;
                w_ovf_nxt = wrap_en;
            end else begin
                w_cnt_nxt = w_up_sum[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= RST_VAL;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
            r_udf <= w_udf_nxt;
        end
    end

endmodule

// File: tb/tb_updn_counter_param.sv
// Randomised self-checking bench for updn_counter_param against an integer reference model.
module tb_updn_counter_param;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic [4:0] IN;
    logic       load, Down, Up, wrap_en;
    logic [4:0] lim_lo, lim_hi, step;
    logic [4:0] Counter;
    logic       High, Low, ovf, udf, cfg_err;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_cnt;
    int m_ovf;
    int m_udf;
    bit chk_en = 1'b0;

    updn_counter_param #(.WIDTH(5), .RST_VAL(5'd0)) dut (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .IN      (IN),
        .load    (load),
        .Down    (Down),
        .Up      (Up),
        .wrap_en (wrap_en),
        .lim_lo  (lim_lo),
        .lim_hi  (lim_hi),
`ifdef UPDN_STEP_EN
        .step    (step),
`endif
        .Counter (Counter),
        .High    (High),
        .Low     (Low),
        .ovf     (ovf),
        .udf     (udf),
        .cfg_err (cfg_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the spec's rules in plain integer arithmetic.
    always @(posedge CLK or negedge rst_n) begin
        int s, lo, hi;
        if (!rst_n) begin
            m_cnt = 0; m_ovf = 0; m_udf = 0;
        end else begin
`ifdef UPDN_STEP_EN
            s = int'(step);
`else
            s = 1;
`endif
            lo = int'(lim_lo);
            hi = int'(lim_hi);
            m_ovf = 0;
            m_udf = 0;
            if (load) m_cnt = int'(IN);
            else if (lo > hi) m_cnt = m_cnt;
            else if (Down) begin
                if (m_cnt <= lo || m_cnt - s < lo) begin
                    if (wrap_en) begin m_cnt = hi; m_udf = 1; end
                    else m_cnt = lo;
                end else m_cnt = m_cnt - s;
            end else if (Up) begin
                if (m_cnt >= hi || m_cnt + s > hi) begin
                    if (wrap_en) begin m_cnt = lo; m_ovf = 1; end
                    else m_cnt = hi;
                end else m_cnt = m_cnt + s;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cnt",  int'(Counter), m_cnt);
            chk("ovf",  int'(ovf),     m_ovf);
            chk("udf",  int'(udf),     m_udf);
            chk("high", int'(High),    int'(m_cnt >= int'(lim_hi)));
            chk("low",  int'(Low),     int'(m_cnt <= int'(lim_lo)));
            chk("cfg",  int'(cfg_err), int'(lim_lo > lim_hi));
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        load = 0; Up = 0; Down = 0;
    endtask

    task automatic do_load(input int v);
        load = 1; IN = 5'(v); Up = 0; Down = 0;
        cyc();
        load = 0;
    endtask

    initial begin
        rst_n = 0; IN = 0; load = 0; Down = 0; Up = 0; wrap_en = 0;
        lim_lo = 0; lim_hi = 31; step = 1;
        #3;
        chk("rst_cnt", int'(Counter), 0);
        chk("rst_low", int'(Low), 1);
        cyc(); cyc();
        rst_n = 1;
        chk_en = 1;

        // 1: saturate at top of full range
        Up = 1;
        repeat (31) cyc();
        chk("t1_cnt31", int'(Counter), 31);
        chk("t1_high", int'(High), 1);
        cyc();
        chk("t1_hold", int'(Counter), 31);
        chk("t1_ovf0", int'(ovf), 0);
        idle();

        // 2: wrap between 4 and 10
        wrap_en = 1; lim_lo = 4; lim_hi = 10;
        do_load(9);
        Up = 1;
        cyc();
        chk("t2_cnt10", int'(Counter), 10);
        cyc();
        chk("t2_wrap4", int'(Counter), 4);
        chk("t2_ovf", int'(ovf), 1);
        Up = 0; Down = 1;
        cyc();
        chk("t2_ovf_clr", int'(ovf), 0);
        chk("t2_dn10", int'(Counter), 10);
        chk("t2_udf", int'(udf), 1);
        idle();
        cyc();
        chk("t2_udf_clr", int'(udf), 0);

`ifdef UPDN_STEP_EN
        // 3: step of 3, saturating
        wrap_en = 0; lim_lo = 0; lim_hi = 20; step = 3;
        do_load(18);
        Up = 1; cyc(); Up = 0;
        chk("t3_sat20", int'(Counter), 20);
        do_load(2);
        Down = 1; cyc(); Down = 0;
        chk("t3_sat0", int'(Counter), 0);
        chk("t3_low", int'(Low), 1);
        step = 1;
`endif

        // 4: load beats Up/Down; Down beats Up
        wrap_en = 0; lim_lo = 0; lim_hi = 31;
        do_load(5);
        load = 1; IN = 17; Up = 1; Down = 1;
        cyc();
        load = 0;
        chk("t4_load17", int'(Counter), 17);
        cyc();
        chk("t4_dn16", int'(Counter), 16);
        idle();

        // 5: inverted limits freeze counting
        lim_lo = 12; lim_hi = 8;
        #1;
        chk("t5_cfg", int'(cfg_err), 1);
        Up = 1; cyc(); Up = 0; Down = 1; cyc(); Down = 0;
        chk("t5_hold", int'(Counter), 16);
        do_load(20);
        chk("t5_load20", int'(Counter), 20);

        // randomised phase
        lim_lo = 0; lim_hi = 31;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(9) == 0) begin
                logic [4:0] a, b;
                a = 5'($urandom); b = 5'($urandom);
                if (a > b && $urandom_range(7) != 0) begin lim_lo = b; lim_hi = a; end
                else begin lim_lo = a; lim_hi = b; end
            end
            load    = ($urandom_range(7) == 0);
            IN      = 5'($urandom);
            Up      = 1'($urandom);
            Down    = ($urandom_range(2) == 0);
            wrap_en = 1'($urandom);
            step    = 5'($urandom_range(5));
            cyc();
        end
        idle();
        step = 1;

        // 6: limit shrink snaps, then asynchronous reset mid-cycle
        wrap_en = 0; lim_lo = 0; lim_hi = 31;
        do_load(25);
        lim_hi = 15;
        Up = 1; cyc();
        chk("t6_snap15", int'(Counter), 15);
        wrap_en = 1; lim_lo = 3;
        cyc(); Up = 0;
        chk("t6_wrap3", int'(Counter), 3);
        chk("t6_ovf", int'(ovf), 1);
        #1;
        rst_n = 0;
        #1;
        chk("t6_rst_cnt", int'(Counter), 0);
        chk("t6_rst_ovf", int'(ovf), 0);
        chk("t6_rst_udf", int'(udf), 0);
        cyc();
        rst_n = 1;
        cyc(); cyc();
        chk_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
